// File: rtl/systolic_ctrl.sv
// systolic_ctrl: pass sequencer for the weight-stationary systolic array.
// One accepted start runs weight preload, activation streaming and pipeline
// drain, then pulses done. All outputs come straight from flops.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; num_vecs latched on acceptance
// S_LOAD   | ARRAY_ROWS weight reads, each loaded into its row one cycle later
// S_STREAM | one activation read per cycle, N cycles
// S_DRAIN  | compute kept enabled while the last vectors leave the array
// S_DONE   | single-cycle completion pulse
module systolic_ctrl #(
  parameter int ARRAY_ROWS = 4,
  parameter int ARRAY_COLS = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [CNT_W-1:0]              num_vecs,
  output logic                          busy,
  output logic                          done,
  output logic                          w_rd_en,
  output logic [$clog2(ARRAY_ROWS)-1:0] w_rd_addr,
  output logic [ARRAY_ROWS-1:0]         load_weight_row,
  output logic                          act_rd_en,
  output logic [CNT_W-1:0]              act_rd_addr,
  output logic                          en_compute,
  output logic                          out_valid,
  output logic [CNT_W-1:0]              out_idx
);

  localparam int LAT = ARRAY_ROWS + ARRAY_COLS;
  localparam int AW  = $clog2(ARRAY_ROWS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] ROWS_C     = CNT_W'(ARRAY_ROWS);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(LAT - 1);

  logic [2:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] n_lat;
  logic [LAT-1:0]   valid_sr;

  // The last-cycle compare against n_lat-1 keeps the counter inside CNT_W
  // even for the largest N, so no wrap before completion.
  // Next-state and phase counter; outputs below are registered from these.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          cnt_nx   = '0;
          state_nx = (num_vecs != '0) ? S_LOAD : S_DONE;
        end
      end
      S_LOAD: begin
        if (cnt == ROWS_C) begin
          state_nx = S_STREAM;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      S_STREAM: begin
        if (cnt == n_lat - ONE) begin
          state_nx = S_DRAIN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      S_DRAIN: begin
        if (cnt == LAST_DRAIN) begin
          state_nx = S_DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // State, counter and pass length; num_vecs is captured only on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      n_lat <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == S_IDLE && start) n_lat <= num_vecs;
    end
  end

  // Registered outputs decoded from the upcoming state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy            <= 1'b0;
      done            <= 1'b0;
      w_rd_en         <= 1'b0;
      w_rd_addr       <= '0;
      load_weight_row <= '0;
      act_rd_en       <= 1'b0;
      act_rd_addr     <= '0;
      en_compute      <= 1'b0;
    end else begin
      busy            <= (state_nx == S_LOAD) || (state_nx == S_STREAM) ||
                         (state_nx == S_DRAIN);
      done            <= (state_nx == S_DONE);
      w_rd_en         <= (state_nx == S_LOAD) && (cnt_nx < ROWS_C);
      w_rd_addr       <= ((state_nx == S_LOAD) && (cnt_nx < ROWS_C)) ?
                         cnt_nx[AW-1:0] : '0;
      load_weight_row <= ((state_nx == S_LOAD) && (cnt_nx != '0)) ?
                         (ARRAY_ROWS'(1) << (cnt_nx - ONE)) : '0;
      act_rd_en       <= (state_nx == S_STREAM);
      act_rd_addr     <= (state_nx == S_STREAM) ? cnt_nx : '0;
      // First streamed vector only reaches the PEs one cycle after its read.
      en_compute      <= ((state_nx == S_STREAM) && (cnt_nx != '0)) ||
                         (state_nx == S_DRAIN);
    end
  end

  // Result-valid is the activation read strobe delayed by the array latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_sr <= '0;
    end else begin
      valid_sr <= {valid_sr[LAT-2:0], act_rd_en};
    end
  end

  assign out_valid = valid_sr[LAT-1];

  // Result index: cleared on accepted start, advances between adjacent valid cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_idx <= '0;
    end else if (state == S_IDLE && start) begin
      out_idx <= '0;
    end else if (valid_sr[LAT-1] && valid_sr[LAT-2]) begin
      out_idx <= out_idx + ONE;
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: cycle-by-cycle check of systolic_ctrl against the
// reference timeline, with a queue scoreboard for the result indices.
module tb_systolic_ctrl;
  localparam int R = 4;
  localparam int C = 4;
  localparam int L = R + C;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  num_vecs;
  logic          busy, done, w_rd_en, act_rd_en, en_compute, out_valid;
  logic [1:0]    w_rd_addr;
  logic [R-1:0]  load_weight_row;
  logic [W-1:0]  act_rd_addr, out_idx;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int ov_total = 0;
  int done_total = 0;

  typedef struct {
    int n;
    int ign_t;
    int extra;
  } vec_t;
  vec_t vecs[6];

  systolic_ctrl #(.ARRAY_ROWS(R), .ARRAY_COLS(C), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vecs(num_vecs),
    .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
    .load_weight_row(load_weight_row), .act_rd_en(act_rd_en),
    .act_rd_addr(act_rd_addr), .en_compute(en_compute),
    .out_valid(out_valid), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  task automatic check_zero(input string name);
    checks++;
    if ({busy, done, w_rd_en, w_rd_addr, load_weight_row, act_rd_en,
         act_rd_addr, en_compute, out_valid, out_idx} != '0) begin
      errors++;
      $display("FAIL %s: outputs not all zero busy=%b done=%b w_en=%b lwr=%b act_en=%b en_c=%b ov=%b idx=%0d, want all 0",
               name, busy, done, w_rd_en, load_weight_row, act_rd_en, en_compute, out_valid, out_idx);
    end
  endtask

  // t = cycles since the cycle in which start was sampled.
  task automatic check_cycle(input int t, input int n);
    logic e_busy, e_done, e_w, e_act, e_en, e_ov;
    logic [R-1:0] e_lwr;
    logic [9:0] exp_f, act_f;
    int exp_i;
    if (n == 0) begin
      e_busy = 1'b0; e_done = (t == 1); e_w = 1'b0; e_lwr = '0;
      e_act = 1'b0; e_en = 1'b0; e_ov = 1'b0;
    end else begin
      e_busy = (t >= 1) && (t <= R + 1 + n + L);
      e_done = (t == R + 2 + n + L);
      e_w    = (t >= 1) && (t <= R);
      e_lwr  = ((t >= 2) && (t <= R + 1)) ? R'(1 << (t - 2)) : '0;
      e_act  = (t >= R + 2) && (t <= R + 1 + n);
      e_en   = (t >= R + 3) && (t <= R + 1 + n + L);
      e_ov   = (t >= R + 2 + L) && (t <= R + 1 + L + n);
    end
    exp_f = {e_busy, e_done, e_w, e_lwr, e_act, e_en, e_ov};
    act_f = {busy, done, w_rd_en, load_weight_row, act_rd_en, en_compute, out_valid};
    checks++;
    if (act_f !== exp_f) begin
      errors++;
      $display("FAIL flags n=%0d t=%0d got=%b want=%b (busy,done,w_en,lwr[3:0],act_en,en_c,ov)",
               n, t, act_f, exp_f);
    end
    if (e_w && w_rd_en) begin
      checks++;
      if (w_rd_addr !== 2'(t - 1)) begin
        errors++;
        $display("FAIL w_rd_addr n=%0d t=%0d got=%0d want=%0d", n, t, w_rd_addr, t - 1);
      end
    end
    if (e_act && act_rd_en) begin
      checks++;
      if (act_rd_addr !== W'(t - R - 2)) begin
        errors++;
        $display("FAIL act_rd_addr n=%0d t=%0d got=%0d want=%0d", n, t, act_rd_addr, t - R - 2);
      end
    end
    checks++;
    if (out_valid) begin
      ov_total++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_idx n=%0d t=%0d unexpected result idx=%0d, want none", n, t, out_idx);
      end else begin
        exp_i = exp_q.pop_front();
        if (out_idx !== W'(exp_i)) begin
          errors++;
          $display("FAIL out_idx n=%0d t=%0d got=%0d want=%0d", n, t, out_idx, exp_i);
        end
      end
    end else begin
      exp_i = (n == 0 || t < R + 2 + L) ? 0 : n - 1;
      if (out_idx !== W'(exp_i)) begin
        errors++;
        $display("FAIL out_idx_hold n=%0d t=%0d got=%0d want=%0d", n, t, out_idx, exp_i);
      end
    end
    if (done) done_total++;
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_pass(input int n, input int ign_t, input int extra, input int abort_t);
    int tend, d0, o0;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(i);
    d0 = done_total;
    o0 = ov_total;
    start = 1'b1;
    num_vecs = W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    num_vecs = W'(n) ^ W'(5);
    tend = (n == 0) ? 1 : R + 2 + n + L;
    for (int t = 1; t <= tend + extra; t++) begin
      check_cycle(t, n);
      if (t == abort_t) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero("abort");
        return;
      end
      if (t == ign_t) begin
        start = 1'b1;
        num_vecs = W'(9);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (exp_q.size() != 0 || done_total - d0 != 1 || ov_total - o0 != n) begin
      errors++;
      $display("FAIL pass_end n=%0d left=%0d done_pulses=%0d valid_cycles=%0d, want left=0 done_pulses=1 valid_cycles=%0d",
               n, exp_q.size(), done_total - d0, ov_total - o0, n);
    end
  endtask

  initial begin
    int d0, o0;
    vecs[0] = '{n: 3, ign_t: 0, extra: 2};
    vecs[1] = '{n: 1, ign_t: 0, extra: 2};
    vecs[2] = '{n: 5, ign_t: 0, extra: 2};
    vecs[3] = '{n: 0, ign_t: 0, extra: 2};
    vecs[4] = '{n: 3, ign_t: 7, extra: 2};
    vecs[5] = '{n: 2, ign_t: 0, extra: 2};

    rst = 1'b1;
    start = 1'b1;
    num_vecs = W'(5);
    repeat (3) begin
      @(posedge clk); #1;
      check_zero("reset");
    end
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_pass(vecs[i].n, vecs[i].ign_t, vecs[i].extra, 0);

    // Abort on the first result cycle, then a clean pass.
    run_pass(3, 0, 0, R + 2 + L);
    repeat (2) begin
      @(posedge clk); #1;
      check_zero("abort_idle");
    end
    run_pass(2, 0, 2, 0);

    // Back-to-back: second start in the cycle right after done.
    d0 = done_total;
    o0 = ov_total;
    run_pass(1, 0, 0, 0);
    run_pass(2, 0, 2, 0);
    checks++;
    if (done_total - d0 != 2 || ov_total - o0 != 3) begin
      errors++;
      $display("FAIL back_to_back done_pulses=%0d valid_cycles=%0d, want 2 and 3",
               done_total - d0, ov_total - o0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
